// File: rtl/axis_accum_bcd.sv
// AXI-Stream packet accumulator: sums the beats of each packet, then converts
// the total to packed BCD with a serial double-dabble engine.
module axis_accum_bcd #(
    parameter int W        = 3,
    parameter int SUM_W    = 7,
    parameter int DIGITS   = 2,
    parameter int SATURATE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [W-1:0]          s_data,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [SUM_W-1:0]      m_sum,
    output logic [4*DIGITS-1:0]   m_bcd,
    output logic                  m_sum_ovf,
    output logic                  m_bcd_ovf,
    output logic [SUM_W-1:0]      acc_sum
);

    typedef enum logic [1:0] {ACC, CONV, OUT} state_t;

    localparam int CW = $clog2(SUM_W + 1);
    localparam logic [63:0] BCD_MAX = 64'(10 ** DIGITS - 1);

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [SUM_W-1:0]    bits;
    logic [4*DIGITS-1:0] bcd;
    logic                ovf;

    logic [SUM_W:0]      sum_ext;
    logic [SUM_W-1:0]    sum_next;
    logic                ovf_next;
    logic [4*DIGITS-1:0] bcd_adj;
    logic [4*DIGITS-1:0] bcd_shift;
    logic                fire;

    assign fire = s_valid && s_ready;

    always_comb begin
        sum_ext  = {1'b0, acc_sum} + {{(SUM_W + 1 - W){1'b0}}, s_data};
        sum_next = sum_ext[SUM_W-1:0];
        if (sum_ext[SUM_W] && (SATURATE != 0))
            sum_next = '1;
        ovf_next = ovf | sum_ext[SUM_W];
    end

    // Add-3 correction per digit; the top digit's carry-out falls off on shift
    always_comb begin
        bcd_adj = bcd;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd[4*k +: 4] >= 4'd5)
                bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
        end
        bcd_shift = {bcd_adj[4*DIGITS-2:0], bits[SUM_W-1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACC;
            s_ready   <= 1'b0;
            m_valid   <= 1'b0;
            m_sum     <= '0;
            m_bcd     <= '0;
            m_sum_ovf <= 1'b0;
            m_bcd_ovf <= 1'b0;
            acc_sum   <= '0;
            ovf       <= 1'b0;
            cnt       <= '0;
            bits      <= '0;
            bcd       <= '0;
        end else begin
            unique case (state)
                ACC: begin
                    s_ready <= 1'b1;
                    if (fire) begin
                        acc_sum <= sum_next;
                        ovf     <= ovf_next;
                        if (s_last) begin
                            m_sum     <= sum_next;
                            m_sum_ovf <= ovf_next;
                            m_bcd_ovf <= 64'(sum_next) > BCD_MAX;
                            acc_sum   <= '0;
                            ovf       <= 1'b0;
                            bits      <= sum_next;
                            bcd       <= '0;
                            cnt       <= '0;
                            s_ready   <= 1'b0;
                            state     <= CONV;
                        end
                    end
                end
                CONV: begin
                    if (cnt == CW'(SUM_W)) begin
                        m_bcd   <= bcd;
                        m_valid <= 1'b1;
                        state   <= OUT;
                    end else begin
                        bcd  <= bcd_shift;
                        bits <= bits << 1;
                        cnt  <= cnt + 1'b1;
                    end
                end
                OUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        s_ready <= 1'b1;
                        state   <= ACC;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

endmodule
